// File: rtl/tpu_isa_pkg.sv
// tpu_isa_pkg: opcode map and instruction helpers shared by the sequencer and control unit.
package tpu_isa_pkg;
   localparam int INSTR_W = 16;
   typedef enum logic [2:0] {
      OP_LD     = 3'd0,
      OP_ST     = 3'd1,
      OP_MATMUL = 3'd2,
      OP_ADD    = 3'd3,
      OP_MUL    = 3'd4,
      OP_BCAST  = 3'd5,
      OP_SYNC   = 3'd6,
      OP_HALT   = 3'd7
   } opcode_e;
   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LATCH, S_ISSUE, S_DRAIN, S_HALT} seq_state_e;
   function automatic opcode_e opcode_of(input logic [INSTR_W-1:0] i);
      return opcode_e'(i[INSTR_W-1 -: 3]);
   endfunction
   function automatic logic is_long_op(input opcode_e op);
      return op == OP_LD || op == OP_ST || op == OP_MATMUL;
   endfunction
endpackage

// File: rtl/op_credit_counter.sv
// op_credit_counter: in-flight long-op counter; simultaneous inc/dec cancel, dec at zero flags underflow.
module op_credit_counter #(
   parameter int MAX_OUT = 4,
   parameter int CNT_W = $clog2(MAX_OUT + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_inc,
   input  logic             i_dec,
   output logic [CNT_W-1:0] o_count,
   output logic             o_full,
   output logic             o_empty,
   output logic             o_underflow
);
   logic [CNT_W-1:0] r_count;
   always_ff @(posedge clk or posedge rst)
      if (rst) r_count <= '0;
      else if (i_inc && !i_dec) r_count <= r_count + 1'b1;
      else if (i_dec && !i_inc && !o_empty) r_count <= r_count - 1'b1;
   assign o_count = r_count;
   assign o_full = r_count == CNT_W'(MAX_OUT);
   assign o_empty = r_count == '0;
   assign o_underflow = i_dec && !i_inc && o_empty;
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetches instructions and issues them over valid/ready, gating on outstanding long ops.
// Optional SEQ_PERF_CNT_EN adds saturating stall_cycles / instr_count counters.
module instr_sequencer #(
   parameter int ADDR_W = 8,
   parameter int INSTR_W = tpu_isa_pkg::INSTR_W,
   parameter int MAX_OUT = 4,
   localparam int CNT_W = $clog2(MAX_OUT + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [ADDR_W-1:0]  base_addr,
   output logic               imem_en,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] instr,
   output logic               instr_valid,
   input  logic               instr_ready,
   input  logic               op_done,
   output logic [ADDR_W-1:0]  pc,
   output logic               busy,
   output logic               halted,
   output logic [CNT_W-1:0]   outstanding,
   output logic               err
`ifdef SEQ_PERF_CNT_EN
   ,
   output logic [31:0]        stall_cycles,
   output logic [31:0]        instr_count
`endif
);
   import tpu_isa_pkg::*;
   seq_state_e         r_state;
   logic [ADDR_W-1:0]  r_pc;
   logic [INSTR_W-1:0] r_instr;
   logic               r_err;
   opcode_e            w_op;
   logic               w_can, w_fire, w_start, w_full, w_empty, w_underflow;
   assign w_op = opcode_e'(r_instr[INSTR_W-1 -: 3]);
   // Gate conditions only relax while waiting in ISSUE, so valid never retracts once raised.
   assign w_can = w_op == OP_SYNC ? w_empty : is_long_op(w_op) ? !w_full : 1'b1;
   assign instr_valid = r_state == S_ISSUE && w_op != OP_HALT && w_can;
   assign w_fire = instr_valid && instr_ready;
   assign w_start = start && (r_state == S_IDLE || r_state == S_HALT);
   op_credit_counter #(.MAX_OUT(MAX_OUT), .CNT_W(CNT_W)) u_credit (
      .clk(clk),
      .rst(rst),
      .i_inc(w_fire && is_long_op(w_op)),
      .i_dec(op_done),
      .o_count(outstanding),
      .o_full(w_full),
      .o_empty(w_empty),
      .o_underflow(w_underflow)
   );
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_state <= S_IDLE;
         r_pc <= '0;
         r_instr <= '0;
         r_err <= 1'b0;
      end else begin
         r_err <= r_err | w_underflow;
         case (r_state)
            S_IDLE, S_HALT: if (w_start) begin
               r_state <= S_FETCH;
               r_pc <= base_addr;
            end
            S_FETCH: r_state <= S_LATCH;
            S_LATCH: begin
               r_instr <= imem_rdata;
               r_state <= S_ISSUE;
            end
            S_ISSUE:
               if (w_op == OP_HALT) r_state <= S_DRAIN;
               else if (w_fire) begin
                  r_pc <= r_pc + 1'b1;
                  r_state <= S_FETCH;
               end
            S_DRAIN: if (w_empty) r_state <= S_HALT;
            default: r_state <= S_IDLE;
         endcase
      end
   assign imem_en = r_state == S_FETCH;
   assign imem_addr = r_pc;
   assign instr = r_instr;
   assign pc = r_pc;
   assign busy = r_state != S_IDLE && r_state != S_HALT;
   assign halted = r_state == S_HALT;
   assign err = r_err;
`ifdef SEQ_PERF_CNT_EN
   logic [31:0] r_stall, r_icnt;
   always_ff @(posedge clk or posedge rst)
      if (rst || w_start) begin
         r_stall <= '0;
         r_icnt <= '0;
      end else begin
         if (r_state == S_ISSUE && !w_fire && r_stall != '1) r_stall <= r_stall + 1'b1;
         if (w_fire && r_icnt != '1) r_icnt <= r_icnt + 1'b1;
      end
   assign stall_cycles = r_stall;
   assign instr_count = r_icnt;
`endif
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed scenarios on a MAX_OUT=4 instance and a MAX_OUT=2 instance sharing one memory.
module tb_instr_sequencer;
   import tpu_isa_pkg::*;
   logic clk = 0, rst = 1;
   logic start = 0, ready = 1, op_done = 0;
   logic start2 = 0, ready2 = 1, op_done2 = 0;
   logic [7:0] base = 0, base2 = 0;
   logic [15:0] mem [256];
   logic [15:0] rdata, rdata2, instr, instr2;
   logic [7:0] iaddr, iaddr2, pc, pc2;
   logic ien, ien2, valid, valid2, busy, busy2, halted, halted2, err, err2;
   logic [2:0] outst;
   logic [1:0] outst2;
   int checks = 0, errors = 0, n, nis;
   logic [15:0] is_i [4];
   logic [7:0] is_p [4];
`ifdef SEQ_PERF_CNT_EN
   logic [31:0] st1, ic1, st2, ic2;
`endif
   always #5 clk = ~clk;
   always @(posedge clk) begin
      if (ien) rdata <= mem[iaddr];
      if (ien2) rdata2 <= mem[iaddr2];
   end
   instr_sequencer #(.MAX_OUT(4)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base), .imem_en(ien), .imem_addr(iaddr),
      .imem_rdata(rdata), .instr(instr), .instr_valid(valid), .instr_ready(ready), .op_done(op_done),
      .pc(pc), .busy(busy), .halted(halted), .outstanding(outst), .err(err)
`ifdef SEQ_PERF_CNT_EN
      , .stall_cycles(st1), .instr_count(ic1)
`endif
   );
   instr_sequencer #(.MAX_OUT(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .base_addr(base2), .imem_en(ien2), .imem_addr(iaddr2),
      .imem_rdata(rdata2), .instr(instr2), .instr_valid(valid2), .instr_ready(ready2), .op_done(op_done2),
      .pc(pc2), .busy(busy2), .halted(halted2), .outstanding(outst2), .err(err2)
`ifdef SEQ_PERF_CNT_EN
      , .stall_cycles(st2), .instr_count(ic2)
`endif
   );
   function automatic logic [15:0] mk(input logic [2:0] op, input logic [12:0] f);
      return {op, f};
   endfunction
   task automatic step();
      @(negedge clk);
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   initial begin
      for (int i = 0; i < 256; i++) mem[i] = mk(OP_HALT, 0);
      mem[8'h10] = mk(OP_ADD, 13'h001);
      mem[8'h11] = mk(OP_MUL, 13'h002);
      mem[8'h20] = mk(OP_ADD, 13'h123);
      mem[8'h30] = mk(OP_LD, 13'h000);
      mem[8'h31] = mk(OP_ST, 13'h000);
      mem[8'h32] = mk(OP_MATMUL, 13'h000);
      mem[8'h40] = mk(OP_LD, 13'h040);
      mem[8'h41] = mk(OP_LD, 13'h041);
      mem[8'h42] = mk(OP_SYNC, 13'h000);
      mem[8'hFF] = mk(OP_ADD, 13'h1FFF);
      mem[8'h50] = mk(OP_LD, 13'h001);
      mem[8'h51] = mk(OP_LD, 13'h002);
      mem[8'h52] = mk(OP_LD, 13'h003);
      mem[8'h53] = mk(OP_ADD, 13'h055);
      #2;
      chk("rst_pc", 32'(pc), 0);
      chk("rst_instr", 32'(instr), 0);
      chk("rst_flags", {valid, busy, halted, err, ien}, 0);
      chk("rst_outst", 32'(outst), 0);
      step();
      rst = 0;
      step();
      chk("idle_busy", 32'(busy), 0);
      // Scenario 1: ADD, MUL, HALT at 0x10
      start = 1; base = 8'h10;
      step();
      start = 0; nis = 0;
      for (n = 0; n < 40 && !halted; n++) begin
         if (valid && ready && nis < 4) begin
            is_i[nis] = instr; is_p[nis] = pc; nis++;
         end
         step();
      end
      chk("s1_timeout", 32'(n < 40), 1);
      chk("s1_nissue", nis, 2);
      chk("s1_i0", 32'(is_i[0]), 32'h6001);
      chk("s1_p0", 32'(is_p[0]), 32'h10);
      chk("s1_i1", 32'(is_i[1]), 32'h8002);
      chk("s1_p1", 32'(is_p[1]), 32'h11);
      chk("s1_halted", 32'(halted), 1);
      chk("s1_pc", 32'(pc), 32'h12);
      chk("s1_busy", 32'(busy), 0);
      // Scenario 2: back-pressure holds instr/valid
      ready = 0; start = 1; base = 8'h20;
      step();
      start = 0;
      for (n = 0; n < 20 && !valid; n++) step();
      chk("s2_timeout", 32'(n < 20), 1);
      for (int k = 0; k < 5; k++) begin
         chk("s2_hold_valid", 32'(valid), 1);
         chk("s2_hold_instr", 32'(instr), 32'h6123);
         chk("s2_hold_pc", 32'(pc), 32'h20);
         step();
      end
      ready = 1;
      step();
      chk("s2_pc_adv", 32'(pc), 32'h21);
      chk("s2_valid_drop", 32'(valid), 0);
      for (n = 0; n < 20 && !halted; n++) step();
      chk("s2_halted", 32'(halted), 1);
      // Scenario 3: MAX_OUT=2 credit stall on MATMUL
      start2 = 1; base2 = 8'h30;
      step();
      start2 = 0;
      for (n = 0; n < 30 && pc2 != 8'h32; n++) step();
      chk("s3_timeout", 32'(n < 30), 1);
      repeat (4) step();
      chk("s3_stall_valid", 32'(valid2), 0);
      chk("s3_stall_outst", 32'(outst2), 2);
      chk("s3_stall_pc", 32'(pc2), 32'h32);
      op_done2 = 1;
      step();
      op_done2 = 0;
      chk("s3_rel_valid", 32'(valid2), 1);
      chk("s3_rel_instr", 32'(instr2), 32'h4000);
      chk("s3_rel_outst", 32'(outst2), 1);
      step();
      chk("s3_acc_outst", 32'(outst2), 2);
      chk("s3_acc_pc", 32'(pc2), 32'h33);
      repeat (4) step();
      chk("s3_drain", {busy2, halted2}, 2'b10);
      op_done2 = 1; step(); op_done2 = 0; step();
      op_done2 = 1; step(); op_done2 = 0;
      for (n = 0; n < 10 && !halted2; n++) step();
      chk("s3_halted", 32'(halted2), 1);
      chk("s3_outst0", 32'(outst2), 0);
      chk("s3_err", 32'(err2), 0);
`ifdef SEQ_PERF_CNT_EN
      chk("s3_stall_cycles", st2, 4);
      chk("s3_instr_count", ic2, 3);
`endif
      // Scenario 4: LD, LD (with simultaneous op_done), SYNC
      start = 1; base = 8'h40;
      step();
      start = 0;
      for (n = 0; n < 30 && !(valid && pc == 8'h41); n++) step();
      chk("s4_timeout", 32'(n < 30), 1);
      op_done = 1;
      step();
      op_done = 0;
      chk("s4_balanced", 32'(outst), 1);
      repeat (3) step();
      chk("s4_sync_wait", 32'(valid), 0);
      chk("s4_sync_pc", 32'(pc), 32'h42);
      op_done = 1;
      step();
      op_done = 0;
      chk("s4_sync_outst", 32'(outst), 0);
      chk("s4_sync_valid", 32'(valid), 1);
      chk("s4_sync_instr", 32'(instr), 32'hC000);
      step();
      chk("s4_sync_pc_adv", 32'(pc), 32'h43);
      for (n = 0; n < 20 && !halted; n++) step();
      chk("s4_halted", 32'(halted), 1);
      chk("s4_err", 32'(err), 0);
      // Scenario 5: underflow error, PC wrap
      op_done = 1;
      step();
      op_done = 0;
      chk("s5_err", 32'(err), 1);
      chk("s5_outst", 32'(outst), 0);
      repeat (3) step();
      chk("s5_err_sticky", 32'(err), 1);
      start = 1; base = 8'hFF;
      step();
      start = 0;
      for (n = 0; n < 20 && !(valid && pc == 8'hFF); n++) step();
      chk("s5_timeout", 32'(n < 20), 1);
      step();
      chk("s5_wrap_pc", 32'(pc), 0);
      chk("s5_wrap_fetch", {ien, iaddr}, 9'h100);
      for (n = 0; n < 20 && !halted; n++) step();
      chk("s5_halt_pc", 32'(pc), 0);
      chk("s5_err_kept", 32'(err), 1);
      // Scenario 6: async reset mid-ISSUE with 3 outstanding
      start = 1; base = 8'h50;
      step();
      start = 0;
      for (n = 0; n < 40 && pc != 8'h53; n++) step();
      chk("s6_timeout", 32'(n < 40), 1);
      ready = 0;
      repeat (3) step();
      chk("s6_pre_valid", 32'(valid), 1);
      chk("s6_pre_outst", 32'(outst), 3);
      #2 rst = 1;
      #1;
      chk("s6_pc", 32'(pc), 0);
      chk("s6_instr", 32'(instr), 0);
      chk("s6_flags", {valid, busy, halted, err, ien}, 0);
      chk("s6_outst", 32'(outst), 0);
      chk("s6_dut2", {halted2, 6'(outst2), pc2}, 0);
      step();
      rst = 0; ready = 1;
      step();
      chk("s6_idle", {busy, valid}, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
